// File: rtl/fc_stream_buffer.sv
// Capture-and-serialise buffer: latches a parallel vector on save, then streams it word by word
// with data/valid delayed to match the weight-ROM latency. FC_STREAM_DOUBLE_BUF_EN enables a second ping-pong bank.
module fc_stream_buffer #(
    parameter int DATA_W    = 16,
    parameter int NUM_WORDS = 120,
    parameter int ADDR_W    = 7,
    parameter int ROM_LAT   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        save,
    input  logic [NUM_WORDS*DATA_W-1:0] din,
    input  logic                        stall,
    output logic                        rom_en,
    output logic [ADDR_W-1:0]           addr,
    output logic [DATA_W-1:0]           dout,
    output logic                        dout_valid,
    output logic                        last,
    output logic                        busy,
    output logic                        overflow
);
`ifdef FC_STREAM_DOUBLE_BUF_EN
    localparam int NUM_BANKS = 2;
    localparam logic BANK_TOGGLE = 1'b1;
`else
    localparam int NUM_BANKS = 1;
    localparam logic BANK_TOGGLE = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state_reg, state_next;
    logic [NUM_BANKS-1:0]  full_reg, full_next;
    logic                  wr_bank_reg, wr_bank_next;
    logic                  rd_bank_reg, rd_bank_next;
    logic [ADDR_W-1:0]     idx_reg, idx_next;
    logic                  overflow_reg, overflow_next;

    logic [DATA_W-1:0]     bank_mem [NUM_BANKS][NUM_WORDS];
    logic [DATA_W-1:0]     din_words [NUM_WORDS];
    logic [DATA_W-1:0]     rd_word;

    logic                  issue, last_issue, save_accept, other_full;

    logic [ROM_LAT-1:0]    pipe_valid_reg, pipe_last_reg;
    logic [DATA_W-1:0]     pipe_data_reg [ROM_LAT];
    logic [ROM_LAT-1:0]    valid_in, last_in;
    logic [DATA_W-1:0]     data_in [ROM_LAT];

    genvar gi;

    // Word 0 sits in the MSBs of din.
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_unpack
            assign din_words[gi] = din[(NUM_WORDS-gi)*DATA_W-1 -: DATA_W];
        end
    endgenerate

`ifdef FC_STREAM_DOUBLE_BUF_EN
    assign other_full = full_reg[~rd_bank_reg];
`else
    assign other_full = 1'b0;
`endif

    assign issue       = (state_reg == STREAM) && !stall;
    assign last_issue  = issue && (idx_reg == LAST_IDX);
    // The bank being drained stays full through its last-issue cycle.
    assign save_accept = save && !full_reg[wr_bank_reg];
    assign rd_word     = bank_mem[rd_bank_reg][idx_reg];

    always_comb begin
        state_next    = state_reg;
        full_next     = full_reg;
        wr_bank_next  = wr_bank_reg;
        rd_bank_next  = rd_bank_reg;
        idx_next      = idx_reg;
        overflow_next = overflow_reg | (save & ~save_accept);
        if (last_issue)
            full_next[rd_bank_reg] = 1'b0;
        if (save_accept) begin
            full_next[wr_bank_reg] = 1'b1;
            wr_bank_next           = wr_bank_reg ^ BANK_TOGGLE;
        end
        case (state_reg)
            IDLE: begin
                if ((|full_reg) || save_accept)
                    state_next = STREAM;
            end
            STREAM: begin
                if (last_issue) begin
                    idx_next     = '0;
                    rd_bank_next = rd_bank_reg ^ BANK_TOGGLE;
                    if (!other_full)
                        state_next = IDLE;
                end else if (issue) begin
                    idx_next = idx_reg + ADDR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            full_reg     <= '0;
            wr_bank_reg  <= 1'b0;
            rd_bank_reg  <= 1'b0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            full_reg     <= full_next;
            wr_bank_reg  <= wr_bank_next;
            rd_bank_reg  <= rd_bank_next;
            idx_reg      <= idx_next;
            overflow_reg <= overflow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (save_accept) begin
            for (int k = 0; k < NUM_WORDS; k++)
                bank_mem[wr_bank_reg][k] <= din_words[k];
        end
    end

    // The delay pipe free-runs so words already issued keep moving during a stall.
    generate
        for (gi = 0; gi < ROM_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign valid_in[gi] = issue;
                assign last_in[gi]  = last_issue;
                assign data_in[gi]  = rd_word;
            end else begin : g_tail
                assign valid_in[gi] = pipe_valid_reg[gi-1];
                assign last_in[gi]  = pipe_last_reg[gi-1];
                assign data_in[gi]  = pipe_data_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid_reg <= '0;
            pipe_last_reg  <= '0;
            for (int k = 0; k < ROM_LAT; k++)
                pipe_data_reg[k] <= '0;
        end else begin
            pipe_valid_reg <= valid_in;
            pipe_last_reg  <= last_in;
            pipe_data_reg  <= data_in;
        end
    end

    assign rom_en     = issue;
    assign addr       = idx_reg;
    assign dout       = pipe_data_reg[ROM_LAT-1];
    assign dout_valid = pipe_valid_reg[ROM_LAT-1];
    assign last       = pipe_last_reg[ROM_LAT-1];
    assign busy       = (|full_reg) || (|pipe_valid_reg);
    assign overflow   = overflow_reg;

endmodule
